pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Sequences the fetch program counter: boot, redirect and stall control in front of the PC register.
//  Arbitrates three redirect requesters (trap, EX branch, ID jal) and the stall sources (hazard hold, fetch bus).
//  Drives the PC's rstn/jump/jump_addr/nop inputs and the per-stage flush lines.
//  Buffers one redirect while the fetch bus is busy, so no redirect is lost.
// PARAMETERS
//  ADDR_W       32  width of all addresses
//  BOOT_CYCLES  4   cycles pc_rstn stays low after rst falls (legal range >= 1)
// PORTS
//  clk           in   1       core clock
//  rst           in   1       synchronous, active-high reset
//  trap_req      in   1       trap/interrupt redirect (highest priority)
//  trap_addr     in   ADDR_W  trap target
//  ex_br_req     in   1       taken branch / jalr resolved in EX
//  ex_br_addr    in   ADDR_W  branch target
//  id_jal_req    in   1       jal decoded in ID (lowest priority)
//  id_jal_addr   in   ADDR_W  jal target
//  hold_req      in   1       hazard-unit stall (load-use)
//  ifu_ready     in   1       fetch bus accepts a new PC this cycle
//  pc_rstn       out  1       to PC rstn; 0 = PC loads reset vector
//  pc_jump       out  1       to PC jump
//  pc_jump_addr  out  ADDR_W  to PC jump_addr; bits [1:0] forced to 0
//  pc_nop        out  1       to PC nop (hold PC)
//  flush_if      out  1       kill instruction in IF
//  flush_id      out  1       kill instruction in ID
//  flush_ex      out  1       kill instruction in EX
// BEHAVIOUR
//  - States: BOOT, RUN, PEND. Registered: state, boot_cnt, pend_addr, pend_src[1:0] (0 none, 1 jal, 2 br, 3 trap).
//  - Outputs are combinational from the registered state and the current inputs: a redirect reaches the PC in the same cycle.
//  - rst=1 (any state, any cycle):
//    - next state is BOOT with boot_cnt=BOOT_CYCLES-1; pend_src=0; pend_addr=0.
//    - While rst=1: pc_rstn=0, pc_jump=0, pc_jump_addr=0, pc_nop=0, flush_*=1.
//  - BOOT:
//    - pc_rstn=0, pc_jump=0, pc_nop=0, flush_*=1. All requests are ignored.
//    - boot_cnt decrements each cycle; when boot_cnt==0 the next state is RUN.
//  - RUN: sel = highest-priority asserted request (trap > ex_br > id_jal).
//    - sel valid, ifu_ready=1: pc_jump=1, pc_jump_addr=sel addr; stay RUN.
//    - sel valid, ifu_ready=0: pc_nop=1; capture sel addr/src into pend_addr/pend_src; next state PEND.
//    - No request, and (hold_req=1 or ifu_ready=0): pc_nop=1.
//    - No request, no stall: pc_jump=0, pc_nop=0; PC increments.
//    - A redirect overrides hold_req in the same cycle.
//  - Flushes (asserted only in the cycle a request is accepted or captured):
//    - trap: flush_if, flush_id, flush_ex.
//    - ex_br: flush_if, flush_id.
//    - id_jal: flush_if.
//  - PEND:
//    - ifu_ready=0: pc_nop=1.
//    - ifu_ready=1: pc_jump=1, pc_jump_addr=pend_addr, pend_src<=0; next state RUN.
//    - hold_req is ignored in PEND.
//    - A new request with priority strictly greater than pend_src replaces pend_addr/pend_src and raises its flushes.
//      If ifu_ready=1 in that same cycle, the new address is the one issued.
//    - Requests of equal or lower priority are ignored.
//  - Invariants:
//    - pc_jump and pc_nop are never both 1.
//    - pc_rstn=0 forces pc_jump=pc_nop=0.
//    - Addresses pass through unmodified except bits [1:0], which are cleared; no arithmetic on them.
// CONFIGURATION
//  - Macro PC_REDIRECT_PERF_EN, when defined:
//    - Adds outputs redirect_cnt[31:0] and stall_cnt[31:0].
//    - redirect_cnt +1 for each cycle with pc_jump=1.
//    - stall_cnt +1 for each cycle with pc_nop=1 in RUN/PEND.
//    - Both counters wrap at 2^32 and clear to 0 on rst.
//  - Macro undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. rst=1 for 2 cycles, BOOT_CYCLES=4, then rst=0 -> pc_rstn=0 and flush_*=1 for 2+4 cycles; pc_rstn=1 in the 7th cycle.
//  2. RUN, ex_br_req=1, ex_br_addr=0x80, ifu_ready=1 -> same cycle pc_jump=1, pc_jump_addr=0x80, flush_if=flush_id=1, flush_ex=0.
//  3. RUN, trap_req(0x100) + id_jal_req(0x40) + hold_req together -> pc_jump=1, addr 0x100, all flushes=1, pc_nop=0.
//  4. RUN, id_jal_req(0x40) with ifu_ready=0 for 3 cycles, trap_req(0x200) in the 2nd cycle, then ifu_ready=1
//     -> pc_nop=1 for 3 cycles; then pc_jump=1, addr 0x200; state back to RUN.
//  5. PEND holding br(0x80), rst=1 for 1 cycle -> pending dropped; BOOT entered; no pc_jump to 0x80 after boot.
//     Also: RUN hold_req=1 for 2 cycles -> pc_nop=1 for 2 cycles, flushes=0.
//  6. PC_REDIRECT_PERF_EN defined: 3 accepted redirects + 5 stall cycles -> redirect_cnt=3, stall_cnt=5; rst -> both 0.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Sequences the fetch program counter. Holds the PC in reset for a boot
// window, arbitrates the redirect requesters (trap > EX branch > ID jal),
// applies stalls from the hazard unit and the fetch bus, and keeps one
// redirect pending while the fetch bus is busy so that it is never lost.
//
// Outputs are combinational from the registered state and the current
// inputs, so an accepted redirect reaches the PC in the same cycle.
//
// Handshake: the fetch bus takes a new PC only in a cycle with
// ifu_ready=1. A redirect presented while ifu_ready=0 is captured into
// the pending slot and issued in the first later cycle with ifu_ready=1.
// Requesters are level signals and are not acknowledged back.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   trap_req/addr    trap redirect (highest priority)
//   ex_br_req/addr   branch / jalr resolved in EX
//   id_jal_req/addr  jal decoded in ID (lowest priority)
//   hold_req         hazard stall, ignored while a redirect is pending
//   ifu_ready        fetch bus accepts a PC this cycle
//   pc_rstn          0 = PC loads its reset vector
//   pc_jump          PC loads pc_jump_addr
//   pc_jump_addr     redirect target, bits [1:0] cleared
//   pc_nop           PC holds its value
//   flush_if/id/ex   kill the instruction in the named stage
//   dbg_state        current FSM state (0 BOOT, 1 RUN, 2 PEND)
//
// Optional build macro PC_REDIRECT_PERF_EN adds redirect_cnt (cycles with
// pc_jump=1) and stall_cnt (cycles with pc_nop=1 in RUN/PEND).
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BOOT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_addr,
  input  logic              ex_br_req,
  input  logic [ADDR_W-1:0] ex_br_addr,
  input  logic              id_jal_req,
  input  logic [ADDR_W-1:0] id_jal_addr,
  input  logic              hold_req,
  input  logic              ifu_ready,
  output logic              pc_rstn,
  output logic              pc_jump,
  output logic [ADDR_W-1:0] pc_jump_addr,
  output logic              pc_nop,
  output logic              flush_if,
  output logic              flush_id,
  output logic              flush_ex,
  output logic [1:0]        dbg_state
`ifdef PC_REDIRECT_PERF_EN
  ,
  output logic [31:0]       redirect_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_INIT = CNT_W'(BOOT_CYCLES - 1);

  // Request source encoding doubles as priority: larger value wins.
  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_JAL  = 2'd1;
  localparam logic [1:0] SRC_BR   = 2'd2;
  localparam logic [1:0] SRC_TRAP = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]        pend_src_q, pend_src_d;

  logic [1:0]        sel_src;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        eff_src;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] jump_addr_raw;
  logic [2:0]        flush_vec;

  // Flush depth grows with how late in the pipe the redirect was decided.
  function automatic logic [2:0] flush_of(input logic [1:0] src);
    case (src)
      SRC_TRAP: flush_of = 3'b111;
      SRC_BR:   flush_of = 3'b110;
      SRC_JAL:  flush_of = 3'b100;
      default:  flush_of = 3'b000;
    endcase
  endfunction

  // Fixed-priority select among the live requesters.
  always_comb begin
    sel_src  = SRC_NONE;
    sel_addr = '0;
    if (trap_req) begin
      sel_src  = SRC_TRAP;
      sel_addr = trap_addr;
    end else if (ex_br_req) begin
      sel_src  = SRC_BR;
      sel_addr = ex_br_addr;
    end else if (id_jal_req) begin
      sel_src  = SRC_JAL;
      sel_addr = id_jal_addr;
    end
  end

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pend_addr_d   = pend_addr_q;
    pend_src_d    = pend_src_q;
    eff_src       = pend_src_q;
    eff_addr      = pend_addr_q;
    pc_rstn       = 1'b1;
    pc_jump       = 1'b0;
    pc_nop        = 1'b0;
    jump_addr_raw = '0;
    flush_vec     = 3'b000;

    case (state_q)
      ST_BOOT: begin
        pc_rstn   = 1'b0;
        flush_vec = 3'b111;
        if (boot_cnt_q == '0) state_d = ST_RUN;
        else                  boot_cnt_d = boot_cnt_q - 1'b1;
      end

      ST_RUN: begin
        if (sel_src != SRC_NONE) begin
          // A redirect wins over hold_req in the same cycle.
          flush_vec = flush_of(sel_src);
          if (ifu_ready) begin
            pc_jump       = 1'b1;
            jump_addr_raw = sel_addr;
          end else begin
            pc_nop      = 1'b1;
            pend_addr_d = sel_addr;
            pend_src_d  = sel_src;
            state_d     = ST_PEND;
          end
        end else if (hold_req || !ifu_ready) begin
          pc_nop = 1'b1;
        end
      end

      ST_PEND: begin
        // Only a strictly higher-priority request displaces the pending one.
        if (sel_src > pend_src_q) begin
          flush_vec = flush_of(sel_src);
          eff_src   = sel_src;
          eff_addr  = sel_addr;
        end
        if (ifu_ready) begin
          pc_jump       = 1'b1;
          jump_addr_raw = eff_addr;
          pend_addr_d   = eff_addr;
          pend_src_d    = SRC_NONE;
          state_d       = ST_RUN;
        end else begin
          pc_nop      = 1'b1;
          pend_addr_d = eff_addr;
          pend_src_d  = eff_src;
        end
      end

      default: begin
        pc_rstn    = 1'b0;
        flush_vec  = 3'b111;
        boot_cnt_d = BOOT_INIT;
        state_d    = ST_BOOT;
      end
    endcase

    // Reset overrides every output and next-state decision above.
    if (rst) begin
      state_d       = ST_BOOT;
      boot_cnt_d    = BOOT_INIT;
      pend_addr_d   = '0;
      pend_src_d    = SRC_NONE;
      pc_rstn       = 1'b0;
      pc_jump       = 1'b0;
      pc_nop        = 1'b0;
      jump_addr_raw = '0;
      flush_vec     = 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    boot_cnt_q  <= boot_cnt_d;
    pend_addr_q <= pend_addr_d;
    pend_src_q  <= pend_src_d;
  end

  assign pc_jump_addr = {jump_addr_raw[ADDR_W-1:2], 2'b00};
  assign flush_if     = flush_vec[2];
  assign flush_id     = flush_vec[1];
  assign flush_ex     = flush_vec[0];
  assign dbg_state    = state_q;

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] redirect_cnt_q, stall_cnt_q;
  logic        in_flow;

  assign in_flow = (state_q == ST_RUN) || (state_q == ST_PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (pc_jump)            redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (pc_nop && in_flow)  stall_cnt_q    <= stall_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed bench for pc_redirect_ctrl. Inputs change 1 ns after a rising
// edge; combinational outputs are sampled 1 ns later, well before the next
// edge. ctl packs {pc_rstn, pc_jump, pc_nop, flush_if, flush_id, flush_ex}.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

  localparam int ADDR_W = 32;
  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic              clk;
  logic              rst;
  logic              trap_req;
  logic [ADDR_W-1:0] trap_addr;
  logic              ex_br_req;
  logic [ADDR_W-1:0] ex_br_addr;
  logic              id_jal_req;
  logic [ADDR_W-1:0] id_jal_addr;
  logic              hold_req;
  logic              ifu_ready;
  logic              pc_rstn;
  logic              pc_jump;
  logic [ADDR_W-1:0] pc_jump_addr;
  logic              pc_nop;
  logic              flush_if;
  logic              flush_id;
  logic              flush_ex;
  logic [1:0]        dbg_state;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0]       redirect_cnt;
  logic [31:0]       stall_cnt;
`endif

  logic [5:0] ctl;
  assign ctl = {pc_rstn, pc_jump, pc_nop, flush_if, flush_id, flush_ex};

  int checks = 0;
  int errors = 0;

  pc_redirect_ctrl #(.ADDR_W(ADDR_W), .BOOT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .trap_req     (trap_req),
    .trap_addr    (trap_addr),
    .ex_br_req    (ex_br_req),
    .ex_br_addr   (ex_br_addr),
    .id_jal_req   (id_jal_req),
    .id_jal_addr  (id_jal_addr),
    .hold_req     (hold_req),
    .ifu_ready    (ifu_ready),
    .pc_rstn      (pc_rstn),
    .pc_jump      (pc_jump),
    .pc_jump_addr (pc_jump_addr),
    .pc_nop       (pc_nop),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .flush_ex     (flush_ex),
    .dbg_state    (dbg_state)
`ifdef PC_REDIRECT_PERF_EN
    ,
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    trap_req   = 1'b0;
    ex_br_req  = 1'b0;
    id_jal_req = 1'b0;
    hold_req   = 1'b0;
  endtask

  // Reset for one cycle and walk through the 4 boot cycles into RUN.
  task automatic do_reset();
    clear_reqs();
    ifu_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_reqs();
    ifu_ready = 1'b1;
    rst = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (ctl !== 6'b000111) begin
        errors++;
        $display("FAIL reset_ctl cyc%0d: ctl=%b exp=%b", c, ctl, 6'b000111);
      end
      checks++;
      if (pc_jump_addr !== 32'h0) begin
        errors++;
        $display("FAIL reset_addr cyc%0d: addr=%h exp=0", c, pc_jump_addr);
      end
      tick();
    end
    rst = 1'b0;
    // Requests during boot must be ignored.
    trap_req  = 1'b1;
    trap_addr = 32'h0000_0500;
    for (int c = 3; c <= 6; c++) begin
      #1;
      checks++;
      if (ctl !== 6'b000111) begin
        errors++;
        $display("FAIL boot_ctl cyc%0d: ctl=%b exp=%b", c, ctl, 6'b000111);
      end
      checks++;
      if (dbg_state !== S_BOOT) begin
        errors++;
        $display("FAIL boot_state cyc%0d: state=%0d exp=%0d", c, dbg_state, S_BOOT);
      end
      tick();
    end
    trap_req = 1'b0;
    #1;
    checks++;
    if (ctl !== 6'b100000) begin
      errors++;
      $display("FAIL run_ctl cyc7: ctl=%b exp=%b", ctl, 6'b100000);
    end
    checks++;
    if (dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL run_state cyc7: state=%0d exp=%0d", dbg_state, S_RUN);
    end
    tick();
  endtask

  task automatic test_ex_branch();
    ex_br_req  = 1'b1;
    ex_br_addr = 32'h0000_0080;
    ifu_ready  = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b110110) begin
      errors++;
      $display("FAIL br_ctl: ctl=%b exp=%b", ctl, 6'b110110);
    end
    checks++;
    if (pc_jump_addr !== 32'h0000_0080) begin
      errors++;
      $display("FAIL br_addr: addr=%h exp=%h", pc_jump_addr, 32'h0000_0080);
    end
    tick();
    // Low address bits are cleared on the way through.
    ex_br_addr = 32'hABCD_008B;
    #1;
    checks++;
    if (pc_jump_addr !== 32'hABCD_0088) begin
      errors++;
      $display("FAIL br_align: addr=%h exp=%h", pc_jump_addr, 32'hABCD_0088);
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if (ctl !== 6'b100000) begin
      errors++;
      $display("FAIL br_idle: ctl=%b exp=%b", ctl, 6'b100000);
    end
    tick();
  endtask

  task automatic test_priority();
    trap_req    = 1'b1;
    trap_addr   = 32'h0000_0100;
    id_jal_req  = 1'b1;
    id_jal_addr = 32'h0000_0040;
    hold_req    = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b110111) begin
      errors++;
      $display("FAIL prio_trap_ctl: ctl=%b exp=%b", ctl, 6'b110111);
    end
    checks++;
    if (pc_jump_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL prio_trap_addr: addr=%h exp=%h", pc_jump_addr, 32'h0000_0100);
    end
    tick();
    clear_reqs();
    ex_br_req   = 1'b1;
    ex_br_addr  = 32'h0000_0C00;
    id_jal_req  = 1'b1;
    #1;
    checks++;
    if (pc_jump_addr !== 32'h0000_0C00 || ctl !== 6'b110110) begin
      errors++;
      $display("FAIL prio_br: addr=%h ctl=%b exp addr=%h ctl=%b",
               pc_jump_addr, ctl, 32'h0000_0C00, 6'b110110);
    end
    tick();
    clear_reqs();
    id_jal_req = 1'b1;
    #1;
    checks++;
    if (pc_jump_addr !== 32'h0000_0040 || ctl !== 6'b110100) begin
      errors++;
      $display("FAIL prio_jal: addr=%h ctl=%b exp addr=%h ctl=%b",
               pc_jump_addr, ctl, 32'h0000_0040, 6'b110100);
    end
    tick();
    clear_reqs();
  endtask

  task automatic test_hold();
    hold_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ctl !== 6'b101000) begin
        errors++;
        $display("FAIL hold cyc%0d: ctl=%b exp=%b", c, ctl, 6'b101000);
      end
      tick();
    end
    hold_req  = 1'b0;
    ifu_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== 6'b101000) begin
      errors++;
      $display("FAIL ifu_stall: ctl=%b exp=%b", ctl, 6'b101000);
    end
    tick();
    ifu_ready = 1'b1;
  endtask

  task automatic test_pend_replace();
    id_jal_req  = 1'b1;
    id_jal_addr = 32'h0000_0040;
    ifu_ready   = 1'b0;
    #1;
    checks++;
    if (ctl !== 6'b101100) begin
      errors++;
      $display("FAIL pend_cap: ctl=%b exp=%b", ctl, 6'b101100);
    end
    tick();
    id_jal_req = 1'b0;
    trap_req   = 1'b1;
    trap_addr  = 32'h0000_0200;
    hold_req   = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b101111 || dbg_state !== S_PEND) begin
      errors++;
      $display("FAIL pend_trap: ctl=%b state=%0d exp ctl=%b state=%0d",
               ctl, dbg_state, 6'b101111, S_PEND);
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if (ctl !== 6'b101000) begin
      errors++;
      $display("FAIL pend_wait: ctl=%b exp=%b", ctl, 6'b101000);
    end
    tick();
    ifu_ready = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b110000 || pc_jump_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL pend_issue: ctl=%b addr=%h exp ctl=%b addr=%h",
               ctl, pc_jump_addr, 6'b110000, 32'h0000_0200);
    end
    tick();
    #1;
    checks++;
    if (dbg_state !== S_RUN || ctl !== 6'b100000) begin
      errors++;
      $display("FAIL pend_back: state=%0d ctl=%b exp state=%0d ctl=%b",
               dbg_state, ctl, S_RUN, 6'b100000);
    end
    tick();
  endtask

  task automatic test_pend_priority();
    // Lower-priority request while a branch is pending is ignored.
    ex_br_req  = 1'b1;
    ex_br_addr = 32'h0000_0080;
    ifu_ready  = 1'b0;
    tick();
    clear_reqs();
    id_jal_req  = 1'b1;
    id_jal_addr = 32'h0000_0044;
    ifu_ready   = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b110000 || pc_jump_addr !== 32'h0000_0080) begin
      errors++;
      $display("FAIL pend_low: ctl=%b addr=%h exp ctl=%b addr=%h",
               ctl, pc_jump_addr, 6'b110000, 32'h0000_0080);
    end
    tick();
    clear_reqs();
    // Higher-priority request replaces and issues in the same cycle.
    id_jal_req  = 1'b1;
    id_jal_addr = 32'h0000_0048;
    ifu_ready   = 1'b0;
    tick();
    clear_reqs();
    ex_br_req  = 1'b1;
    ex_br_addr = 32'h0000_0300;
    ifu_ready  = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b110110 || pc_jump_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL pend_same_cyc: ctl=%b addr=%h exp ctl=%b addr=%h",
               ctl, pc_jump_addr, 6'b110110, 32'h0000_0300);
    end
    tick();
    clear_reqs();
  endtask

  task automatic test_rst_in_pend();
    ex_br_req  = 1'b1;
    ex_br_addr = 32'h0000_0080;
    ifu_ready  = 1'b0;
    tick();
    clear_reqs();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== 6'b000111 || pc_jump_addr !== 32'h0) begin
      errors++;
      $display("FAIL pend_rst: ctl=%b addr=%h exp ctl=%b addr=0",
               ctl, pc_jump_addr, 6'b000111);
    end
    tick();
    rst       = 1'b0;
    ifu_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ctl !== 6'b000111) begin
        errors++;
        $display("FAIL pend_rst_boot cyc%0d: ctl=%b exp=%b", c, ctl, 6'b000111);
      end
      tick();
    end
    #1;
    checks++;
    if (ctl !== 6'b100000 || dbg_state !== S_RUN) begin
      errors++;
      $display("FAIL pend_dropped: ctl=%b state=%0d exp ctl=%b state=%0d",
               ctl, dbg_state, 6'b100000, S_RUN);
    end
    tick();
  endtask

`ifdef PC_REDIRECT_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      ex_br_req  = 1'b1;
      ex_br_addr = 32'h0000_1000 + 32'(c * 16);
      tick();
    end
    clear_reqs();
    hold_req = 1'b1;
    repeat (5) tick();
    hold_req = 1'b0;
    #1;
    checks++;
    if (redirect_cnt !== 32'd3 || stall_cnt !== 32'd5) begin
      errors++;
      $display("FAIL perf_cnt: redirect=%0d stall=%0d exp 3 5", redirect_cnt, stall_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (redirect_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_rst: redirect=%0d stall=%0d exp 0 0", redirect_cnt, stall_cnt);
    end
    repeat (4) tick();
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    rst         = 1'b1;
    trap_addr   = '0;
    ex_br_addr  = '0;
    id_jal_addr = '0;
    ifu_ready   = 1'b1;
    clear_reqs();
    #1;
    test_reset();
    test_ex_branch();
    test_priority();
    test_hold();
    test_pend_replace();
    test_pend_priority();
    test_rst_in_pend();
    do_reset();
`ifdef PC_REDIRECT_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
